// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers.
// Provides the occupancy state encoding, ID/EX control bit positions and the
// default bundle widths used at each stage boundary.
package pipe_pkg;

    // Occupancy state; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

    // ID/EX control bundle bit positions.
    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_ALU_OP_LSB = 3;
    localparam int unsigned CTRL_ALU_OP_MSB = 5;
    localparam int unsigned CTRL_ALU_SRC    = 6;
    localparam int unsigned CTRL_BRANCH     = 7;
    localparam int unsigned CTRL_STR_IND    = 8;

    // Default bundle widths per stage boundary.
    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IFID_DATA_W  = 64;
    localparam int unsigned IDEX_CTRL_W  = 9;
    localparam int unsigned IDEX_DATA_W  = 79;
    localparam int unsigned EXMEM_CTRL_W = 4;
    localparam int unsigned EXMEM_DATA_W = 53;
    localparam int unsigned MEMWB_CTRL_W = 2;
    localparam int unsigned MEMWB_DATA_W = 37;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake channel carrying a control and a data bundle.
// master: drives valid/ctrl/data, receives ready.
// slave : receives valid/ctrl/data, drives ready.
interface pipe_stage_skid_if #(
    parameter int unsigned CTRL_WIDTH = pipe_pkg::IDEX_CTRL_W,
    parameter int unsigned DATA_WIDTH = pipe_pkg::IDEX_DATA_W
);
    logic                  valid;
    logic                  ready;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output ctrl,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  ctrl,
        input  data,
        output ready
    );

endinterface : pipe_stage_skid_if

// File: rtl/pipe_slot.sv
// One storage slot of the skid buffer: a {ctrl, data} register with a load
// enable and independent clear enables for the ctrl and data fields.
// Ports: clk, reset (async active-high, zeroes both fields), load, clr_ctrl,
//        clr_data (clears win over load), d_ctrl/d_data in, q_ctrl/q_data out.
module pipe_slot #(
    parameter int unsigned CTRL_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 79
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clr_ctrl,
    input  logic                  clr_data,
    input  logic [CTRL_WIDTH-1:0] d_ctrl,
    input  logic [DATA_WIDTH-1:0] d_data,
    output logic [CTRL_WIDTH-1:0] q_ctrl,
    output logic [DATA_WIDTH-1:0] q_data
);

    // Control field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_ctrl <= '0;
        end else if (clr_ctrl) begin
            q_ctrl <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
        end
    end

    // Data field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_data <= '0;
        end else if (clr_data) begin
            q_data <= '0;
        end else if (load) begin
            q_data <= d_data;
        end
    end

endmodule : pipe_slot

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a two-entry skid buffer.
// Back-pressure is absorbed by the skid slot, so up.ready depends on the
// state register only and never on dn.ready.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      squash held entries and any same-cycle input
//   up         slave side of the upstream channel (valid/ctrl/data in, ready out)
//   dn         master side of the downstream channel (valid/ctrl/data out, ready in)
//   occupancy  number of held entries (0..2)
// Optional macro: PIPE_ZERO_ON_FLUSH_EN -- flush also zeroes both data slots.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH = IDEX_CTRL_W,
    parameter int unsigned DATA_WIDTH = IDEX_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    pipe_stage_skid_if.slave        up,
    pipe_stage_skid_if.master       dn,
    output logic [1:0]              occupancy
);

    pipe_state_e state_q;
    pipe_state_e state_d;

    logic                  up_ready;
    logic                  dn_valid;
    logic                  accept;
    logic                  pop;

    logic                  head_load;
    logic                  head_from_skid;
    logic                  head_clr_ctrl;
    logic                  skid_load;
    logic                  skid_clr_ctrl;
    logic                  data_clr;

    logic [CTRL_WIDTH-1:0] head_d_ctrl;
    logic [DATA_WIDTH-1:0] head_d_data;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;

    // Handshake terms derived from the state register only.
    assign up_ready = (state_q != PS_TWO);
    assign dn_valid = (state_q != PS_EMPTY);
    assign accept   = up.valid & up_ready & ~flush;
    assign pop      = dn_valid & dn.ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and slot control.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        head_clr_ctrl  = 1'b0;
        skid_load      = 1'b0;
        skid_clr_ctrl  = 1'b0;
        data_clr       = 1'b0;

        if (flush) begin
            // Any same-cycle pop is already owned by downstream.
            state_d       = PS_EMPTY;
            head_clr_ctrl = 1'b1;
            skid_clr_ctrl = 1'b1;
`ifdef PIPE_ZERO_ON_FLUSH_EN
            data_clr      = 1'b1;
`else
            data_clr      = 1'b0;
`endif
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        state_d   = PS_ONE;
                        head_load = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        state_d   = PS_TWO;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d       = PS_EMPTY;
                        head_clr_ctrl = 1'b1;
                        skid_clr_ctrl = 1'b1;
                    end
                end
                PS_TWO: begin
                    if (pop) begin
                        state_d        = PS_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                end
            endcase
        end
    end

    // Head refills from the skid slot when draining, else from upstream.
    assign head_d_ctrl = head_from_skid ? skid_ctrl : up.ctrl;
    assign head_d_data = head_from_skid ? skid_data : up.data;

    pipe_slot #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_head (
        .clk      (clk),
        .reset    (reset),
        .load     (head_load),
        .clr_ctrl (head_clr_ctrl),
        .clr_data (data_clr),
        .d_ctrl   (head_d_ctrl),
        .d_data   (head_d_data),
        .q_ctrl   (head_ctrl),
        .q_data   (head_data)
    );

    pipe_slot #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clr_ctrl (skid_clr_ctrl),
        .clr_data (data_clr),
        .d_ctrl   (up.ctrl),
        .d_data   (up.data),
        .q_ctrl   (skid_ctrl),
        .q_data   (skid_data)
    );

    // Masking keeps stale enables off the bus even if a slot is ever dirty.
    assign up.ready  = up_ready;
    assign dn.valid  = dn_valid;
    assign dn.ctrl   = head_ctrl & {CTRL_WIDTH{dn_valid}};
    assign dn.data   = head_data;
    assign occupancy = 2'(state_q);

endmodule : pipe_stage_skid
